// File: rtl/xgmii_tlp_tx_bridge.sv
// Pulls TLP beats from the XGMII-RX FIFO and re-frames them onto the PCIe core's 64-bit AXI4-Stream TX port.
// Gap entries are dropped, and truncated or oversize TLPs are closed with the source-discontinue flag.
module xgmii_tlp_tx_bridge #(
  parameter int MaxBeats = 130
) (
  input  logic        clk,
  input  logic        sys_rst_n,
  input  logic [71:0] dout,
  input  logic        empty,
  output logic        rd_en,
  output logic [63:0] s_axis_tx_tdata,
  output logic [7:0]  s_axis_tx_tkeep,
  output logic        s_axis_tx_tlast,
  output logic        s_axis_tx_tvalid,
  input  logic        s_axis_tx_tready,
  output logic [3:0]  s_axis_tx_tuser,
  output logic [15:0] tlp_count,
  output logic [7:0]  dsc_count,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, TLP, DISCARD} state_t;

  localparam logic [7:0] MAX_BEATS = 8'(MaxBeats);

  state_t     state;
  logic [7:0] beat_cnt;
  logic [7:0] next_cnt;
  logic       ent_valid;
  logic       ent_last;
  logic [7:0] ent_keep;
  logic       load_ok;
  logic       drop;
  logic       take;
  logic       dummy;

  // A beat flagged valid but with no DW enabled carries nothing, so it is handled as a gap.
  assign ent_valid = dout[64] & (dout[66] | dout[67]);
  assign ent_last  = dout[65];
  assign ent_keep  = {{4{dout[67]}}, {4{dout[66]}}};
  assign load_ok   = !s_axis_tx_tvalid | s_axis_tx_tready;

  assign drop  = !empty & (((state == IDLE) & !ent_valid) | (state == DISCARD));
  assign take  = !empty & load_ok & ent_valid & (state != DISCARD);
  // The gap that ends a truncated frame stays in the FIFO; it is consumed later in IDLE.
  assign dummy = !empty & load_ok & !ent_valid & (state == TLP);
  assign rd_en = sys_rst_n & (drop | take);

  assign next_cnt = (beat_cnt == 8'hFF) ? 8'hFF : beat_cnt + 8'd1;
  assign busy     = (state != IDLE) | s_axis_tx_tvalid;

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state            <= IDLE;
      beat_cnt         <= 8'd0;
      tlp_count        <= 16'd0;
      dsc_count        <= 8'd0;
      s_axis_tx_tdata  <= 64'd0;
      s_axis_tx_tkeep  <= 8'd0;
      s_axis_tx_tlast  <= 1'b0;
      s_axis_tx_tuser  <= 4'd0;
      s_axis_tx_tvalid <= 1'b0;
    end else begin
      if (take || dummy) begin
        s_axis_tx_tvalid <= 1'b1;
      end else if (s_axis_tx_tready) begin
        s_axis_tx_tvalid <= 1'b0;
      end

      if (take) begin
        s_axis_tx_tdata <= dout[63:0];
        s_axis_tx_tkeep <= ent_keep;
        s_axis_tx_tlast <= ent_last;
        s_axis_tx_tuser <= 4'd0;
        if (state == IDLE) begin
          beat_cnt <= 8'd1;
          if (ent_last) begin
            tlp_count <= tlp_count + 16'd1;
          end else begin
            state <= TLP;
          end
        end else begin
          beat_cnt <= next_cnt;
          if (ent_last) begin
            tlp_count <= tlp_count + 16'd1;
            state     <= IDLE;
          end else if (next_cnt == MAX_BEATS) begin
            // Oversize: this beat closes the packet as discontinued; the rest of the frame is discarded.
            s_axis_tx_tlast <= 1'b1;
            s_axis_tx_tuser <= 4'b1000;
            dsc_count       <= (dsc_count == 8'hFF) ? 8'hFF : dsc_count + 8'd1;
            state           <= DISCARD;
          end
        end
      end else if (dummy) begin
        s_axis_tx_tdata <= 64'd0;
        s_axis_tx_tkeep <= 8'h0F;
        s_axis_tx_tlast <= 1'b1;
        s_axis_tx_tuser <= 4'b1000;
        dsc_count       <= (dsc_count == 8'hFF) ? 8'hFF : dsc_count + 8'd1;
        state           <= IDLE;
      end else if (drop && (state == DISCARD) && (ent_last || !ent_valid)) begin
        state <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_xgmii_tlp_tx_bridge.sv
// Scoreboard bench for xgmii_tlp_tx_bridge: a queue-modelled FWFT FIFO feeds directed frames,
// expected beats are queued at stimulus time and checked by a separate monitor at each handshake.
module tb_xgmii_tlp_tx_bridge;

  logic        clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [71:0] dout = 72'd0;
  logic        empty = 1'b1;
  logic        rd_en;
  logic [63:0] tdata;
  logic [7:0]  tkeep;
  logic        tlast;
  logic        tvalid;
  logic        tready = 1'b1;
  logic [3:0]  tuser;
  logic [15:0] tlp_count;
  logic [7:0]  dsc_count;
  logic        busy;

  xgmii_tlp_tx_bridge #(.MaxBeats(130)) dut (
    .clk(clk), .sys_rst_n(sys_rst_n), .dout(dout), .empty(empty), .rd_en(rd_en),
    .s_axis_tx_tdata(tdata), .s_axis_tx_tkeep(tkeep), .s_axis_tx_tlast(tlast),
    .s_axis_tx_tvalid(tvalid), .s_axis_tx_tready(tready), .s_axis_tx_tuser(tuser),
    .tlp_count(tlp_count), .dsc_count(dsc_count), .busy(busy)
  );

  always #5 clk = ~clk;

  logic [71:0] fifo_q[$];
  logic [76:0] exp_q[$];
  int          hs_log[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  logic        pop_pending = 1'b0;
  logic        chk_rd = 1'b0;
  logic        held = 1'b0;
  logic [76:0] snap;

  function automatic logic [71:0] ent(input logic [3:0] ctl, input logic [63:0] d);
    return {4'd0, ctl, d};
  endfunction

  task automatic refresh();
    if (fifo_q.size() > 0) begin
      dout  = fifo_q[0];
      empty = 1'b0;
    end else begin
      dout  = 72'd0;
      empty = 1'b1;
    end
  endtask

  task automatic push(input logic [3:0] ctl, input logic [63:0] d);
    fifo_q.push_back(ent(ctl, d));
    refresh();
  endtask

  task automatic expect_beat(input logic [63:0] d, input logic [7:0] k, input logic l, input logic [3:0] u);
    exp_q.push_back({d, k, l, u});
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (!(fifo_q.size() == 0 && exp_q.size() == 0 && !busy) && n < 600) begin
      @(posedge clk);
      #2;
      n++;
    end
    check({name, "_drain_timeout"}, (n >= 600) ? 1 : 0, 0);
  endtask

  // FIFO model: the pop decision is latched at the negedge and applied just after the next edge.
  always @(posedge clk) begin
    logic [71:0] tmp;
    #1;
    if (pop_pending && fifo_q.size() > 0) tmp = fifo_q.pop_front();
    pop_pending = 1'b0;
    refresh();
  end

  always @(negedge clk) begin
    logic [76:0] e;
    cyc++;
    pop_pending = rd_en;
    if (tvalid && tready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_beat: got data=%h keep=%h last=%b user=%h, required none", tdata, tkeep, tlast, tuser);
      end else begin
        e = exp_q.pop_front();
        if ({tdata, tkeep, tlast, tuser} !== e) begin
          n_bad++;
          $display("FAIL beat: got data=%h keep=%h last=%b user=%h, required data=%h keep=%h last=%b user=%h",
                   tdata, tkeep, tlast, tuser, e[76:13], e[12:5], e[4], e[3:0]);
        end
      end
      hs_log.push_back(cyc);
    end
    if (held && tvalid) check("hold_stable", 32'({tdata, tkeep, tlast, tuser} == snap), 1);
    if (chk_rd && tvalid && !tready && !empty && dout[64]) check("rd_en_while_full", 32'(rd_en), 0);
    held = tvalid && !tready;
    snap = {tdata, tkeep, tlast, tuser};
  end

  initial begin
    // Reset state
    #1;
    check("rst_tvalid", 32'(tvalid), 0);
    check("rst_rd_en", 32'(rd_en), 0);
    check("rst_busy", 32'(busy), 0);
    repeat (3) step();
    sys_rst_n = 1'b1;
    step();

    // 1: 3DW header + 1DW payload, tready held high
    push(4'hD, 64'h0000_0001_4000_0001);
    push(4'h7, 64'hCAFE_F00D_1234_5678);
    repeat (6) push(4'h0, 64'd0);
    expect_beat(64'h0000_0001_4000_0001, 8'hFF, 1'b0, 4'h0);
    expect_beat(64'hCAFE_F00D_1234_5678, 8'h0F, 1'b1, 4'h0);
    wait_idle("t1");
    check("t1_tlp_count", 32'(tlp_count), 1);
    check("t1_dsc_count", 32'(dsc_count), 0);
    check("t1_busy", 32'(busy), 0);

    // 2: same TLP with tready 1,0,0,1
    chk_rd = 1'b1;
    push(4'hD, 64'h1111_2222_3333_4444);
    push(4'h7, 64'h5555_6666_7777_8888);
    repeat (6) push(4'h0, 64'd0);
    expect_beat(64'h1111_2222_3333_4444, 8'hFF, 1'b0, 4'h0);
    expect_beat(64'h5555_6666_7777_8888, 8'h0F, 1'b1, 4'h0);
    step();
    tready = 1'b0;
    step();
    check("t2_tvalid_held", 32'(tvalid), 1);
    step();
    tready = 1'b1;
    wait_idle("t2");
    chk_rd = 1'b0;
    check("t2_tlp_count", 32'(tlp_count), 2);

    // 3: truncated frame
    push(4'hD, 64'hAAAA_BBBB_CCCC_DDDD);
    push(4'h0, 64'd0);
    push(4'h0, 64'd0);
    expect_beat(64'hAAAA_BBBB_CCCC_DDDD, 8'hFF, 1'b0, 4'h0);
    expect_beat(64'd0, 8'h0F, 1'b1, 4'h8);
    wait_idle("t3");
    check("t3_dsc_count", 32'(dsc_count), 1);
    check("t3_tlp_count", 32'(tlp_count), 2);

    // 4: oversize frame, 140 x 0D then 0F
    for (int i = 0; i < 140; i++) push(4'hD, 64'(i) + 64'h1000);
    push(4'hF, 64'hDEAD_BEEF_0000_0000);
    push(4'h0, 64'd0);
    for (int i = 0; i < 130; i++)
      expect_beat(64'(i) + 64'h1000, 8'hFF, (i == 129), (i == 129) ? 4'h8 : 4'h0);
    wait_idle("t4");
    check("t4_dsc_count", 32'(dsc_count), 2);
    check("t4_tlp_count", 32'(tlp_count), 2);

    // 5: back-to-back TLPs
    hs_log.delete();
    push(4'hD, 64'h0505_0000_0000_0001);
    push(4'hF, 64'h0505_0000_0000_0002);
    push(4'hD, 64'h0505_0000_0000_0003);
    push(4'h7, 64'h0505_0000_0000_0004);
    push(4'h0, 64'd0);
    expect_beat(64'h0505_0000_0000_0001, 8'hFF, 1'b0, 4'h0);
    expect_beat(64'h0505_0000_0000_0002, 8'hFF, 1'b1, 4'h0);
    expect_beat(64'h0505_0000_0000_0003, 8'hFF, 1'b0, 4'h0);
    expect_beat(64'h0505_0000_0000_0004, 8'h0F, 1'b1, 4'h0);
    wait_idle("t5");
    check("t5_tlp_count", 32'(tlp_count), 4);
    check("t5_hs_count", 32'(hs_log.size()), 4);
    if (hs_log.size() == 4) check("t5_back_to_back", 32'(hs_log[3] - hs_log[0]), 3);

    // 6: reset while the stage holds a beat with tready low
    tready = 1'b0;
    push(4'hD, 64'h6666_0000_0000_0001);
    repeat (3) step();
    check("t6_pre_tvalid", 32'(tvalid), 1);
    sys_rst_n = 1'b0;
    fifo_q.delete();
    exp_q.delete();
    refresh();
    #1;
    check("t6_rst_tvalid", 32'(tvalid), 0);
    check("t6_rst_tlp_count", 32'(tlp_count), 0);
    check("t6_rst_dsc_count", 32'(dsc_count), 0);
    check("t6_rst_busy", 32'(busy), 0);
    step();
    step();
    sys_rst_n = 1'b1;
    tready = 1'b1;
    step();
    push(4'hD, 64'h7777_0000_0000_0001);
    push(4'h7, 64'h7777_0000_0000_0002);
    push(4'h0, 64'd0);
    expect_beat(64'h7777_0000_0000_0001, 8'hFF, 1'b0, 4'h0);
    expect_beat(64'h7777_0000_0000_0002, 8'h0F, 1'b1, 4'h0);
    wait_idle("t6");
    check("t6_tlp_count", 32'(tlp_count), 1);

    repeat (2) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/xgmii_tlp_tx_bridge.md
Name: xgmii_tlp_tx_bridge

Overview:
- Downstream consumer of the XGMII-RX FIFO, which carries 72-bit entries: b63-0 data, b64 valid TLP beat, b65 TLP last, b66 low DW enable, b67 high DW enable.
- Pops entries and drops all-zero gap entries.
- Re-frames TLP beats onto the PCIe core's 64-bit AXI4-Stream TX interface (s_axis_tx_*).
- Truncated or oversize TLPs are terminated with the source-discontinue flag, so the PCIe core never sees a hung packet.

Parameters:
- MaxBeats, 130, maximum beats per TLP (4DW header + 256DW payload); a longer TLP is cut with discontinue.

Ports:
- clk  input  1  core clock; FIFO read side and AXI-S are both on clk.
- sys_rst_n  input  1  asynchronous, active-low reset.
- dout  input  72  FIFO read data, first-word-fall-through (valid whenever empty=0).
- empty  input  1  FIFO empty.
- rd_en  output  1  FIFO pop (combinational).
- s_axis_tx_tdata  output  64  TLP data, passed unmodified from dout[63:0].
- s_axis_tx_tkeep  output  8  byte enables.
- s_axis_tx_tlast  output  1  last beat of TLP.
- s_axis_tx_tvalid  output  1  beat valid.
- s_axis_tx_tready  input  1  core ready.
- s_axis_tx_tuser  output  4  bit3 = src_dsc (discontinue); bits2-0 = 0.
- tlp_count  output  16  TLPs completed with a normal tlast; wraps.
- dsc_count  output  8  TLPs terminated with discontinue; saturates at 8'hFF.
- busy  output  1  1 while state != IDLE or tvalid=1.

Behaviour:
- Output stage: a single register holds tdata/tkeep/tlast/tuser/tvalid.
  - load_ok = !tvalid | tready.
  - When a beat is loaded, tvalid<=1. When tready=1 and nothing is loaded, tvalid<=0.
- Entry decode:
  - gap = !dout[64].
  - last = dout[65].
  - keep = {{4{dout[67]}},{4{dout[66]}}}.
  - An entry with dout[64]=1 and both enables 0 is malformed and is treated as a gap.
- rd_en = !empty & (load_ok | entry_is_dropped).
  - Dropped entries: gap entries in IDLE, and any entry in DISCARD. They pop without needing the output stage.
- State IDLE:
  - Gap: pop and drop.
  - Valid entry: load beat, beat_cnt<=1. If last=1, set tlast=1, tlp_count+1 and stay in IDLE; otherwise go to TLP.
- State TLP, valid entry:
  - Load beat, beat_cnt+1.
  - last=1: tlast=1, tlp_count+1, go to IDLE.
  - Otherwise, if beat_cnt+1 == MaxBeats: tlast=1, tuser[3]=1, dsc_count+1, go to DISCARD. The current beat carries the discontinue.
- State TLP, gap entry (truncated frame):
  - Do not pop. When load_ok, load a dummy beat: tdata=0, tkeep=8'h0F, tlast=1, tuser[3]=1.
  - dsc_count+1, go to IDLE. The gap entry is then consumed in IDLE.
- State DISCARD:
  - Pop and drop every entry.
  - An entry with last=1 or a gap entry returns the block to IDLE. That entry is also dropped.
- Latency: 1 cycle from FIFO head to tvalid when the stage is free; throughput 1 beat/clk while tready=1.
- Output hold: while tvalid=1 & tready=0, all s_axis_tx_* outputs hold stable and nothing is popped except drops.
- Simultaneous tready and load: the new beat replaces the accepted one in the same cycle, with no bubble.
- empty=1 mid-TLP: wait in TLP with no timeout. The producer always follows a frame with gap entries.
- Counter width rules: beat_cnt is 8 bits and saturates; tlp_count wraps at 16'hFFFF→0; dsc_count saturates at 8'hFF.
- Reset (asynchronous, any time, including mid-TLP): state=IDLE, tvalid=0, tlast=0, tuser=0, tdata=0, tkeep=0, beat_cnt=0, tlp_count=0, dsc_count=0, busy=0.
  - rd_en=0 while sys_rst_n=0.
  - A TLP partially sent before reset is not re-terminated; the core is reset alongside.

Test Plan:
1. 3DW memory-write header plus 1DW payload: FIFO entries {0D,hdr01},{07,hdr2|data} followed by 6 gap entries, tready=1 → 2 beats. tkeep FF then 0F, tlast on beat 2, tuser=0, tlp_count=1, all gaps dropped, busy=0 afterwards.
2. Same TLP with tready toggling 1,0,0,1 → beats held stable while tready=0, no beat lost or duplicated, rd_en=0 while the stage is full.
3. Truncated frame: {0D,hdr} followed by a gap entry → beat 1 with tlast=0, then a dummy beat with tdata=0, tkeep=0F, tlast=1, tuser=8, dsc_count=1, state back to IDLE.
4. Oversize frame: 140 consecutive 0D entries then a 0F entry, MaxBeats=130 → 130 beats, beat 130 has tlast=1 and tuser=8. The remaining 11 entries are dropped, dsc_count=1, tlp_count=0.
5. Back-to-back TLPs: 0D,0F,0D,07 with no gap between them, tready=1 → 4 consecutive tvalid cycles, tlast on beats 2 and 4, tlp_count=2.
6. Reset asserted while the stage holds a beat with tready=0 → tvalid=0 immediately. After release, the next FIFO entry, {0D,...}, starts a new TLP normally.
